// File: rtl/updown_counter_p.sv
// updown_counter_p: parametrised up/down counter with enable, load, programmable step and wrap/saturate modes.
// Define UDC_STICKY_EN to build the sticky ovf flag and its clr_ovf input.
module updown_counter_p #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
`ifdef UDC_STICKY_EN
  ,
  output logic             ovf,
  input  logic             clr_ovf
`endif
);

  localparam logic [WIDTH:0]   maxv  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] max_w = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] mod_w = WIDTH'(MAX_VAL + 1);

  logic [WIDTH:0]   stepx;
  logic [WIDTH:0]   s;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ld;
  logic             bnd;

  // Wrap results always fit in WIDTH bits, so modular WIDTH-bit arithmetic is exact.
  always_comb begin
    stepx = {1'b0, step};
    s     = (stepx > maxv) ? maxv : stepx;
    sum   = {1'b0, count} + s;
    nxt   = count;
    bnd   = 1'b0;
    ld    = ({1'b0, load_val} > maxv) ? max_w : load_val;
    if (up_down) begin
      if (sum <= maxv) begin
        nxt = sum[WIDTH-1:0];
      end else begin
        bnd = 1'b1;
        nxt = sat ? max_w : (sum[WIDTH-1:0] - mod_w);
      end
    end else begin
      if ({1'b0, count} >= s) begin
        nxt = count - s[WIDTH-1:0];
      end else begin
        bnd = 1'b1;
        nxt = sat ? '0 : (count + mod_w - s[WIDTH-1:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= ld;
      wrap  <= 1'b0;
    end else if (en) begin
      count <= nxt;
      wrap  <= bnd;
    end else begin
      wrap  <= 1'b0;
    end
  end

`ifdef UDC_STICKY_EN
  // A boundary event on the same edge as clr_ovf keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (!load && en && bnd) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end
`endif

  assign at_max = (count == max_w);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_counter_p.sv
// Randomized scoreboard bench for updown_counter_p: a 4-bit/mod-10 instance and an 8-bit full-range instance
// are driven in lockstep and compared against an arithmetic reference model.
module tb_updown_counter_p;

  localparam int M4 = 9;
  localparam int M8 = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_down = 1'b0;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] step4 = '0;
  logic [3:0] load_val4 = '0;
  logic [7:0] step8 = '0;
  logic [7:0] load_val8 = '0;

  logic [3:0] count4;
  logic       wrap4, at_max4, at_min4;
  logic [7:0] count8;
  logic       wrap8, at_max8, at_min8;
`ifdef UDC_STICKY_EN
  logic       ovf4, ovf8;
`endif

  updown_counter_p #(.WIDTH(4), .MAX_VAL(M4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .sat(sat),
    .step(step4), .load(load), .load_val(load_val4),
    .count(count4), .wrap(wrap4), .at_max(at_max4), .at_min(at_min4)
`ifdef UDC_STICKY_EN
    , .ovf(ovf4), .clr_ovf(clr_ovf)
`endif
  );

  updown_counter_p #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .sat(sat),
    .step(step8), .load(load), .load_val(load_val8),
    .count(count8), .wrap(wrap8), .at_max(at_max8), .at_min(at_min8)
`ifdef UDC_STICKY_EN
    , .ovf(ovf8), .clr_ovf(clr_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    bit w;
    bit o;
  } mstate_t;

  typedef struct {
    mstate_t a;
    mstate_t b;
  } exp_t;

  exp_t    expq[$];
  mstate_t m4 = '{0, 1'b0, 1'b0};
  mstate_t m8 = '{0, 1'b0, 1'b0};
  int      vectors = 0;
  int      miscompares = 0;

  // Reference model: the counter treated as an integer in 0..maxv.
  function automatic mstate_t modelNext(mstate_t cur, int maxv, bit rst, bit ld, int lv,
                                        bit e, bit ud, bit st, int stp, bit clr);
    mstate_t n = cur;
    int s, t;
    if (rst) begin
      n.c = 0; n.w = 0; n.o = 0;
    end else if (ld) begin
      n.c = (lv > maxv) ? maxv : lv;
      n.w = 0;
      if (clr) n.o = 0;
    end else begin
      n.w = 0;
      if (e) begin
        s = (stp > maxv) ? maxv : stp;
        t = ud ? cur.c + s : cur.c - s;
        if (t > maxv) begin
          n.w = 1;
          n.c = st ? maxv : t - (maxv + 1);
        end else if (t < 0) begin
          n.w = 1;
          n.c = st ? 0 : t + (maxv + 1);
        end else begin
          n.c = t;
        end
      end
      if (n.w) n.o = 1;
      else if (clr) n.o = 0;
    end
    return n;
  endfunction

  task automatic checkOutput(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(bit rst, bit ld, int lv, bit e, bit ud, bit st, int stp, bit clr);
    exp_t x;
    @(negedge clk);
    reset = rst; load = ld; en = e; up_down = ud; sat = st; clr_ovf = clr;
    load_val4 = 4'(lv); load_val8 = 8'(lv);
    step4 = 4'(stp); step8 = 8'(stp);
    m4 = modelNext(m4, M4, rst, ld, lv % 16, e, ud, st, stp % 16, clr);
    m8 = modelNext(m8, M8, rst, ld, lv % 256, e, ud, st, stp % 256, clr);
    x.a = m4;
    x.b = m8;
    expq.push_back(x);
  endtask

  // Monitor: every edge presents a new result; compare it against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        checkOutput("count4", int'(count4), x.a.c);
        checkOutput("wrap4", int'(wrap4), int'(x.a.w));
        checkOutput("at_max4", int'(at_max4), int'(x.a.c == M4));
        checkOutput("at_min4", int'(at_min4), int'(x.a.c == 0));
        checkOutput("count8", int'(count8), x.b.c);
        checkOutput("wrap8", int'(wrap8), int'(x.b.w));
        checkOutput("at_max8", int'(at_max8), int'(x.b.c == M8));
        checkOutput("at_min8", int'(at_min8), int'(x.b.c == 0));
`ifdef UDC_STICKY_EN
        checkOutput("ovf4", int'(ovf4), int'(x.a.o));
        checkOutput("ovf8", int'(ovf8), int'(x.b.o));
`endif
      end
    end
  end

  initial begin
    // args: reset, load, load_val, en, up_down, sat, step, clr_ovf
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (11) applyStimulus(0, 0, 0, 1, 1, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 0, 1, 0, 0, 3, 0);
    applyStimulus(0, 1, 7, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 1, 1, 1, 4, 0);
    repeat (2) applyStimulus(0, 0, 0, 1, 0, 1, 9, 0);
    applyStimulus(0, 1, 15, 1, 1, 0, 1, 0);
    applyStimulus(1, 1, 5, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 12, 0);
    repeat (5) applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
    repeat (2) applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 9, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 1, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 1);
    applyStimulus(0, 1, 9, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 1, 1);
    applyStimulus(0, 1, 254, 0, 1, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 1, 1, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                    int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)),
                    $urandom_range(0, 5) == 0);
    end

    repeat (3) @(negedge clk);
    if (expq.size() != 0) checkOutput("drain", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
